// File: rtl/pipe_step_ctrl.sv
// Debug-unit pipeline sequencer: gates the shared latch/PC step enable for continuous
// run or N-cycle stepping, halts on the write-back HALT marker and counts issued cycles.
module pipe_step_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned STEPN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    input  logic [STEPN_W-1:0] i_step_n,
    output logic               o_cmd_ready,
    input  logic               i_stop_pipe,
    output logic               o_step,
    output logic               o_halted,
    output logic               o_busy,
    output logic [2:0]         o_state,
    output logic [CNT_W-1:0]   o_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_RUN    = 3'b001,
        S_STEP   = 3'b010,
        S_HALTED = 3'b011
    } state_e;

    typedef enum logic [1:0] {
        CMD_CLR  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } cmd_e;

    state_e             state;
    logic [STEPN_W-1:0] remaining;
    logic [CNT_W-1:0]   cycle_count;
    logic               accept;
    logic               active;

    assign active        = (state == S_RUN) || (state == S_STEP);
    assign o_step        = active && !i_stop_pipe;
    assign o_cmd_ready   = (state != S_STEP);
    assign accept        = i_cmd_valid && o_cmd_ready;
    assign o_busy        = active;
    assign o_halted      = (state == S_HALTED);
    assign o_state       = state;
    assign o_cycle_count = cycle_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            remaining   <= '0;
            cycle_count <= '0;
        end else begin
            // a clear accepted in the same cycle as a step takes priority
            if (accept && (i_cmd == CMD_CLR))
                cycle_count <= '0;
            else if (o_step && (cycle_count != '1))
                cycle_count <= cycle_count + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (accept && (i_cmd == CMD_RUN)) begin
                        state <= i_stop_pipe ? S_HALTED : S_RUN;
                    end else if (accept && (i_cmd == CMD_STEP)) begin
                        if (i_stop_pipe) begin
                            state <= S_HALTED;
                        end else begin
                            state     <= S_STEP;
                            remaining <= (i_step_n == '0) ? STEPN_W'(1) : i_step_n;
                        end
                    end
                end
                S_RUN: begin
                    // halt marker beats a simultaneous STOP
                    if (i_stop_pipe) begin
                        state     <= S_HALTED;
                        remaining <= '0;
                    end else if (accept && (i_cmd == CMD_STOP)) begin
                        state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (i_stop_pipe) begin
                        state     <= S_HALTED;
                        remaining <= '0;
                    end else if (remaining <= STEPN_W'(1)) begin
                        state     <= S_IDLE;
                        remaining <= '0;
                    end else begin
                        remaining <= remaining - STEPN_W'(1);
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state     <= S_IDLE;
                    remaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Scoreboard bench for pipe_step_ctrl: expectations are queued as stimulus is driven
// and popped when the corresponding DUT outputs are sampled on the falling edge.
module tb_pipe_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_valid4;
    logic [1:0]  cmd, cmd4;
    logic [7:0]  step_n, step_n4;
    logic        stop_pipe, stop_pipe4;
    logic        cmd_ready, cmd_ready4;
    logic        step, step4;
    logic        halted, halted4;
    logic        busy, busy4;
    logic [2:0]  state, state4;
    logic [31:0] cycle_count;
    logic [3:0]  cycle_count4;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    pipe_step_ctrl #(.CNT_W(32), .STEPN_W(8)) dut (
        .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .i_step_n(step_n),
        .o_cmd_ready(cmd_ready), .i_stop_pipe(stop_pipe), .o_step(step), .o_halted(halted),
        .o_busy(busy), .o_state(state), .o_cycle_count(cycle_count)
    );

    pipe_step_ctrl #(.CNT_W(4), .STEPN_W(8)) dut4 (
        .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid4), .i_cmd(cmd4), .i_step_n(step_n4),
        .o_cmd_ready(cmd_ready4), .i_stop_pipe(stop_pipe4), .o_step(step4), .o_halted(halted4),
        .o_busy(busy4), .o_state(state4), .o_cycle_count(cycle_count4)
    );

    always @(negedge clk) if (step) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int unsigned v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 32'd1, 32'd0);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] n);
        cmd_valid = 1'b1; cmd = c; step_n = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send4(input logic [1:0] c);
        cmd_valid4 = 1'b1; cmd4 = c;
        @(negedge clk);
        cmd_valid4 = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (state != 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        cmd_valid = 0; cmd = 0; step_n = 0; stop_pipe = 0;
        cmd_valid4 = 0; cmd4 = 0; step_n4 = 0; stop_pipe4 = 0;
        do_reset();

        push(0); push(0); push(0); push(1); push(0); push(0);
        pop_check("rst_state", 32'(state));
        pop_check("rst_step", 32'(step));
        pop_check("rst_count", cycle_count);
        pop_check("rst_ready", 32'(cmd_ready));
        pop_check("rst_halted", 32'(halted));
        pop_check("rst_busy", 32'(busy));

        // STEP n=3
        p0 = pulses;
        send(2'b10, 8'd3);
        push(0); push(2); push(1);
        pop_check("step3_ready", 32'(cmd_ready));
        pop_check("step3_state", 32'(state));
        pop_check("step3_busy", 32'(busy));
        wait_idle("step3");
        @(negedge clk);
        push(3); push(3); push(0);
        pop_check("step3_pulses", 32'(pulses - p0));
        pop_check("step3_count", cycle_count);
        pop_check("step3_end", 32'(state));

        // STEP n=0, with a RUN presented while stepping
        p0 = pulses;
        send(2'b10, 8'd0);
        push(0);
        pop_check("step0_ready", 32'(cmd_ready));
        cmd_valid = 1'b1; cmd = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        push(1); push(4); push(0);
        pop_check("step0_pulses", 32'(pulses - p0));
        pop_check("step0_count", cycle_count);
        pop_check("step0_state", 32'(state));

        // CLR in IDLE, RUN 10 cycles, STOP
        send(2'b00, 8'd0);
        push(0);
        pop_check("clr_idle", cycle_count);
        send(2'b01, 8'd0);
        repeat (9) @(negedge clk);
        send(2'b11, 8'd0);
        push(10); push(0);
        pop_check("run10_count", cycle_count);
        pop_check("run10_state", 32'(state));

        // RUN resumes from 10; STEP is dropped while running
        send(2'b01, 8'd0);
        push(10);
        pop_check("resume_start", cycle_count);
        send(2'b10, 8'd5);
        push(1);
        pop_check("run_drop_step", 32'(state));
        repeat (2) @(negedge clk);
        send(2'b11, 8'd0);
        push(14); push(0);
        pop_check("resume_count", cycle_count);
        pop_check("resume_state", 32'(state));

        // CLR while running wins over the increment
        send(2'b01, 8'd0);
        repeat (3) @(negedge clk);
        send(2'b00, 8'd0);
        push(0);
        pop_check("clr_run", cycle_count);
        @(negedge clk);
        push(1);
        pop_check("clr_run_inc", cycle_count);
        send(2'b11, 8'd0);
        push(2);
        pop_check("clr_run_stop", cycle_count);

        // halt marker with simultaneous STOP
        send(2'b01, 8'd0);
        stop_pipe = 1'b1; cmd_valid = 1'b1; cmd = 2'b11;
        #1;
        push(0);
        pop_check("halt_step_gated", 32'(step));
        @(negedge clk);
        cmd_valid = 1'b0;
        push(3); push(1); push(0); push(0); push(1); push(2);
        pop_check("halt_state", 32'(state));
        pop_check("halt_flag", 32'(halted));
        pop_check("halt_busy", 32'(busy));
        pop_check("halt_step", 32'(step));
        pop_check("halt_ready", 32'(cmd_ready));
        pop_check("halt_count", cycle_count);
        stop_pipe = 1'b0;
        send(2'b01, 8'd0);
        @(negedge clk);
        push(3); push(0);
        pop_check("halt_sticky", 32'(state));
        pop_check("halt_nostep", 32'(step));
        send(2'b00, 8'd0);
        push(0);
        pop_check("halt_clr", cycle_count);

        do_reset();
        push(0);
        pop_check("halt_exit_rst", 32'(state));

        // STEP from IDLE with marker already present
        stop_pipe = 1'b1;
        send(2'b10, 8'd4);
        push(3); push(0);
        pop_check("idle_step_halt", 32'(state));
        pop_check("idle_step_count", cycle_count);
        stop_pipe = 1'b0;
        do_reset();

        // 4-bit counter saturation and clear
        send4(2'b01);
        repeat (20) @(negedge clk);
        push(15); push(1);
        pop_check("sat_count", 32'(cycle_count4));
        pop_check("sat_state", 32'(state4));
        send4(2'b00);
        push(0);
        pop_check("sat_clr", 32'(cycle_count4));
        @(negedge clk);
        push(1);
        pop_check("sat_clr_inc", 32'(cycle_count4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
